conv_acc_requant: RTL and testbench

- Downstream stage of the conv multiplier (8-bit signed activation x 16-bit signed weight -> 24-bit signed product).
- Accumulates NUM_TAPS consecutive products per output pixel and adds a per-channel bias.
- Requantizes with a rounding right shift and saturates the result to OUT_WIDTH signed.
- Presents the result on a valid/ready stream towards the next layer buffer.

---
 rtl/conv_acc_requant.sv | 90 +++++++++
 tb/tb_conv_acc_requant.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_requant.sv
// Accumulates NUM_TAPS multiplier products plus a per-channel bias, then requantizes with a rounding
// right shift and saturates onto a valid/ready output stream.
module conv_acc_requant #(
    parameter int PROD_WIDTH = 24,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_TAPS   = 9,
    parameter int BIAS_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int XW = ACC_WIDTH + 1;
    localparam logic [7:0] LAST_TAP = 8'(NUM_TAPS - 1);
    localparam logic signed [XW-1:0] OUT_MAX = {{(XW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic signed [XW-1:0] RND = {{(XW - 1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic        [7:0]           tap_cnt_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, base, sum;
    logic signed [XW-1:0]        sum_x, r;
    logic signed [OUT_WIDTH-1:0] out_data_q, res_data;
    logic                        out_sat_q, out_valid_q, res_sat;
    logic                        accept, last_tap;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_tap  = (tap_cnt_q == LAST_TAP);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

    always_comb begin
        prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
        bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias} << SHIFT;
        base     = (tap_cnt_q == 8'd0) ? bias_ext : acc_q;
        sum      = base + prod_ext;
        // One extra bit so adding the rounding constant cannot wrap.
        sum_x    = {sum[ACC_WIDTH-1], sum} + RND;
        r        = sum_x >>> SHIFT;
        res_sat  = 1'b0;
        res_data = r[OUT_WIDTH-1:0];
        if (r > OUT_MAX) begin
            res_data = OUT_MAX[OUT_WIDTH-1:0];
            res_sat  = 1'b1;
        end else if (r < OUT_MIN) begin
            res_data = OUT_MIN[OUT_WIDTH-1:0];
            res_sat  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            tap_cnt_q   <= 8'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (last_tap) begin
                    // Overrides the drain above so back-to-back windows see no bubble.
                    out_valid_q <= 1'b1;
                    out_data_q  <= res_data;
                    out_sat_q   <= res_sat;
                    tap_cnt_q   <= 8'd0;
                    acc_q       <= '0;
                end else begin
                    acc_q     <= sum;
                    tap_cnt_q <= tap_cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_acc_requant.sv
// Directed bench for conv_acc_requant: expected results go to a scoreboard queue when a window is
// driven and are popped when the output handshake completes.
module tb_conv_acc_requant;

    localparam int TAPS = 9;
    localparam int SH   = 8;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [23:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] bias = '0;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready = 1'b1;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    logic [16:0] exp_q[$];
    int          out_cyc[$];

    conv_acc_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        errors++;
        $error("FAIL %s: bound expired", tag);
    endtask

    // Reference result for bias + first + (TAPS-1)*rest.
    function automatic logic [16:0] model(input longint b, input longint first, input longint rest);
        longint s, r;
        s = b * (longint'(1) << SH) + first + (TAPS - 1) * rest;
        r = (s + (longint'(1) << (SH - 1))) >>> SH;
        if (r > 32767) return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'($signed(e[15:0])));
                chk("out_sat", 32'(out_sat), 32'(e[16]));
                out_cyc.push_back(cyc);
            end
        end
    end

    // Leaves in_valid asserted so consecutive calls stream without gaps.
    task automatic push_tap(input logic signed [23:0] d, input logic signed [15:0] b);
        logic rdy;
        int   guard;
        guard    = 0;
        in_data  = d;
        bias     = b;
        in_valid = 1'b1;
        forever begin
            @(negedge ap_clk);
            rdy = in_ready;
            @(posedge ap_clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                fail_now("tap_accept");
                break;
            end
        end
    endtask

    task automatic window(input logic signed [15:0] b, input logic signed [23:0] first,
                          input logic signed [23:0] rest);
        exp_q.push_back(model(b, first, rest));
        push_tap(first, b);
        for (int i = 1; i < TAPS; i++) push_tap(rest, 16'sd0);
    endtask

    task automatic drain_wait();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge ap_clk);
        if (exp_q.size() != 0) begin
            fail_now("output_timeout");
            exp_q.delete();
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        logic [16:0] e;
        int got;
        repeat (3) @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_sat", 32'(out_sat), 0);
        @(posedge ap_clk);
        #1;

        // Basic sum, then result latency check.
        exp_q.push_back(model(0, 256, 256));
        push_tap(24'sd256, 16'sd0);
        for (int i = 1; i < TAPS - 1; i++) push_tap(24'sd256, 16'sd0);
        in_data = 24'sd256;
        @(negedge ap_clk);
        chk("pre_final_valid", 32'(out_valid), 0);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        @(negedge ap_clk);
        chk("latency_valid", 32'(out_valid), 1);
        drain_wait();

        window(0, 128, 0);          drain_wait();
        window(0, -128, 0);         drain_wait();
        window(0, -129, 0);         drain_wait();
        window(100, 0, 0);          drain_wait();
        window(-32768, -256, 0);    drain_wait();
        window(0, 8388607, 8388607);   drain_wait();
        window(0, -8388608, -8388608); drain_wait();
        window(-7, 300, -45);       drain_wait();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        window(3, 512, 64);
        e = model(3, 512, 64);
        in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge ap_clk);
            got = int'(out_valid);
        end
        if (!got) fail_now("bp_valid");
        in_data  = 24'sd2560;
        bias     = 16'sd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ap_clk);
            #1;
            @(negedge ap_clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid_hold", 32'(out_valid), 1);
            chk("bp_data_hold", 32'(out_data), 32'($signed(e[15:0])));
        end
        exp_q.push_back(model(0, 2560, 0));
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_release_ready", 32'(in_ready), 1);
        @(posedge ap_clk);
        #1;
        for (int i = 1; i < TAPS; i++) push_tap(24'sd0, 16'sd0);
        drain_wait();

        // Three windows streamed back to back.
        out_cyc.delete();
        window(0, 256, 256);
        window(1, -1000, 77);
        window(-2, 4096, 4096);
        drain_wait();
        chk("stream_count", 32'(out_cyc.size()), 3);
        if (out_cyc.size() == 3) begin
            chk("stream_gap0", 32'(out_cyc[1] - out_cyc[0]), TAPS);
            chk("stream_gap1", 32'(out_cyc[2] - out_cyc[1]), TAPS);
        end

        // Reset in the middle of a window discards the partial sum.
        for (int i = 0; i < 4; i++) push_tap(24'sd1000, 16'sd0);
        in_valid = 1'b0;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        window(0, 256, 256);
        drain_wait();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
